// File: rtl/sbox_scheduler.sv
// Sequences one 48-bit DES f-function word through a shared S-box lookup port,
// one 6-bit chunk per cycle, and hands back the assembled 32-bit result.
module sbox_scheduler #(
    parameter int REG_LOOKUP = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [47:0] in_data,
    output logic        sb_en,
    output logic [2:0]  sb_sel,
    output logic [5:0]  sb_addr,
    input  logic [3:0]  sb_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t      state_reg;
    logic [47:0] in_reg;
    logic [2:0]  issue_idx_reg;
    logic        sb_en_reg;
    logic [5:0]  sb_addr_reg;
    logic [2:0]  cap_idx_reg;
    logic        pending_reg;
    logic [31:0] result_reg;
    logic        out_valid_reg;
    logic        busy_reg;

    logic [5:0]  chunk [8];
    logic [2:0]  issue_idx_next;
    logic        cap_fire;
    logic [2:0]  cap_nib;

    // Chunk gi feeds S-box gi+1; S1 takes the most significant six bits.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_chunk
            assign chunk[gi] = in_reg[47 - 6*gi -: 6];
        end
    endgenerate

    assign issue_idx_next = issue_idx_reg + 3'd1;

    // With a registered lookup unit the answer trails the request by one
    // cycle, so capture is steered by the delayed strobe and its own index.
    always_comb begin
        cap_fire = sb_en_reg;
        cap_nib  = issue_idx_reg;
        if (REG_LOOKUP != 0) begin
            cap_fire = pending_reg;
            cap_nib  = cap_idx_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            in_reg        <= '0;
            issue_idx_reg <= '0;
            sb_en_reg     <= 1'b0;
            sb_addr_reg   <= '0;
            cap_idx_reg   <= '0;
            pending_reg   <= 1'b0;
            result_reg    <= '0;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        in_reg        <= in_data;
                        issue_idx_reg <= '0;
                        cap_idx_reg   <= '0;
                        pending_reg   <= 1'b0;
                        result_reg    <= '0;
                        sb_en_reg     <= 1'b1;
                        sb_addr_reg   <= in_data[47:42];
                        busy_reg      <= 1'b1;
                        state_reg     <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (sb_en_reg) begin
                        if (issue_idx_reg == 3'd7) begin
                            sb_en_reg     <= 1'b0;
                            issue_idx_reg <= '0;
                            sb_addr_reg   <= '0;
                        end else begin
                            issue_idx_reg <= issue_idx_next;
                            sb_addr_reg   <= chunk[issue_idx_next];
                        end
                    end
                    pending_reg <= sb_en_reg;
                    if (cap_fire) begin
                        // Nibble for S-box n sits at bit (7-n)*4.
                        result_reg[{~cap_nib, 2'b00} +: 4] <= sb_data;
                        cap_idx_reg <= cap_idx_reg + 3'd1;
                        if (cap_nib == 3'd7) begin
                            out_valid_reg <= 1'b1;
                            state_reg     <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_reg == IDLE) && !rst;
    assign sb_en     = sb_en_reg;
    assign sb_sel    = issue_idx_reg;
    assign sb_addr   = sb_addr_reg;
    assign out_valid = out_valid_reg;
    assign out_data  = result_reg;
    assign busy      = busy_reg;

endmodule
